mem_port_arbiter: RTL and testbench

//   Shares one single-ported memory between instruction fetch (read-only) and the

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the data path, one transaction at a time.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_IF = 2'd1,
    ISSUE_DM = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic dm_any;
  logic starve_force;
  logic grant_if;
  logic grant_dm;

  assign dm_any = dm_read | dm_write;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned STARVE_LIM = STARVE_LIMIT;
  logic [3:0] starve_cnt;

  assign starve_force = (32'(starve_cnt) >= STARVE_LIM);

  // Counts arbitrations fetch lost to the data path; saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (state == IDLE) begin
      if (grant_if) begin
        starve_cnt <= 4'd0;
      end else if (if_req && grant_dm && (starve_cnt != 4'hF)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  assign grant_if = if_req & (~dm_any | starve_force);
  assign grant_dm = dm_any & ~grant_if;

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_if) begin
          state_nxt = ISSUE_IF;
        end else if (grant_dm) begin
          state_nxt = ISSUE_DM;
        end
      end
      ISSUE_IF, ISSUE_DM: begin
        if (mem_ready) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side and requester-side registers; valids are single-cycle and land in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_valid  <= 1'b0;
      dm_rdata  <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end else if (grant_dm) begin
            // A simultaneous read and write issues only the write.
            mem_req   <= 1'b1;
            mem_we    <= dm_write;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end
        end
        ISSUE_IF: begin
          if (mem_ready) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
          end
        end
        ISSUE_DM: begin
          if (mem_ready) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
            dm_valid <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: random requesters and memory, checked against a
// transaction-timeline model of the arbitration rules (starvation guard follows MEM_ARB_STARVE_GUARD_EN).
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          dm_read;
  logic          dm_write;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_valid;
  logic [DW-1:0] dm_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic [1:0]    dbg_state;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Stimulus knobs (percent)
  int if_pct    = 0;
  int dm_pct    = 0;
  int ready_pct = 100;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0013_0013;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return AW'($urandom_range(0, 15) * 4);
  endfunction

  // ---------------- memory responder ----------------
  logic [DW-1:0] mem_store [logic [AW-1:0]];
  logic          rsp_req = 1'b0, rsp_we = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] rsp_addr = '0;
  logic [DW-1:0] rsp_wdata = '0;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (!rst && rsp_ready && rsp_req && rsp_we) mem_store[rsp_addr] = rsp_wdata;
      #1;
      rsp_req = mem_req; rsp_we = mem_we; rsp_addr = mem_addr; rsp_wdata = mem_wdata;
      if (mem_req) mem_ready = ($urandom_range(0, 99) < ready_pct);
      else         mem_ready = ($urandom_range(0, 3) == 0);
      rsp_ready = mem_ready;
      if (mem_ready && mem_req && !mem_we)
        mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : init_word(mem_addr);
      else
        mem_rdata = $urandom;
    end
  end

  // ---------------- driver tasks / requesters ----------------
  task automatic drive_fetch();
    logic got;
    @(negedge clk);
    got = if_valid;
    @(posedge clk);
    #1;
    if (if_req && got) if_req = 1'b0;
    if (!if_req && ($urandom_range(0, 99) < if_pct)) begin
      if_req  = 1'b1;
      if_addr = rand_addr();
    end
  endtask

  task automatic drive_data();
    logic got;
    int   kind;
    @(negedge clk);
    got = dm_valid;
    @(posedge clk);
    #1;
    if ((dm_read || dm_write) && got) begin
      dm_read  = 1'b0;
      dm_write = 1'b0;
    end
    if (!(dm_read || dm_write) && ($urandom_range(0, 99) < dm_pct)) begin
      kind     = $urandom_range(0, 7);
      dm_read  = (kind == 0) || (kind >= 4);
      dm_write = (kind <= 3);
      dm_addr  = rand_addr();
      dm_wdata = $urandom;
    end
  endtask

  initial begin
    if_req = 1'b0; if_addr = '0;
    forever drive_fetch();
  end

  initial begin
    dm_read = 1'b0; dm_write = 1'b0; dm_addr = '0; dm_wdata = '0;
    forever drive_data();
  end

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] ref_store [logic [AW-1:0]];
  logic [DW-1:0] exp_q [$];

  bit            resync = 1'b1;
  int            arb_at, grant_at, valid_at = -1, starve;
  bit            in_txn, own_dm, e_we, valid_dm, valid_rd, fwin, dm_any, exp_req;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_if_rdata, e_dm_rdata, popped;

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_store.exists(a) ? ref_store[a] : init_word(a);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      resync = 1'b1;
    end else begin
      if (resync) begin
        arb_at = cyc; in_txn = 1'b0; valid_at = -1; starve = 0;
        e_if_rdata = '0; e_dm_rdata = '0; exp_q.delete(); resync = 1'b0;
      end
      exp_req = in_txn && (cyc > grant_at);
      check("mem_req", mem_req, exp_req);
      check("busy", busy, cyc != arb_at);
      check("if_valid", if_valid, (valid_at == cyc) && !valid_dm);
      check("dm_valid", dm_valid, (valid_at == cyc) && valid_dm);
      if (exp_req) begin
        check("mem_we", mem_we, e_we);
        check("mem_addr", mem_addr, e_addr);
        if (e_we) check("mem_wdata", mem_wdata, e_wdata);
      end
      if ((valid_at == cyc) && valid_rd) begin
        if (exp_q.size() == 0) begin
          check("exp_q_empty", 1'b1, 1'b0);
        end else begin
          popped = exp_q.pop_front();
          if (valid_dm) e_dm_rdata = popped;
          else          e_if_rdata = popped;
        end
      end
      check("if_rdata", if_rdata, e_if_rdata);
      check("dm_rdata", dm_rdata, e_dm_rdata);

      // Completion: memory accepts during an outstanding request.
      if (exp_req && mem_ready) begin
        in_txn   = 1'b0;
        valid_at = cyc + 1;
        arb_at   = cyc + 2;
        valid_dm = own_dm;
        valid_rd = !e_we;
        if (e_we) ref_store[e_addr] = e_wdata;
        else      exp_q.push_back(ref_read(e_addr));
      end

      // Arbitration: data requests win unless fetch has starved long enough.
      if (cyc == arb_at) begin
        dm_any = dm_read || dm_write;
`ifdef MEM_ARB_STARVE_GUARD_EN
        fwin = (starve >= SL);
`else
        fwin = 1'b0;
`endif
        if (if_req && (!dm_any || fwin)) begin
          in_txn = 1'b1; grant_at = cyc; own_dm = 1'b0;
          e_we = 1'b0; e_addr = if_addr; e_wdata = '0;
          starve = 0;
        end else if (dm_any) begin
          in_txn = 1'b1; grant_at = cyc; own_dm = 1'b1;
          e_we = dm_write; e_addr = dm_addr; e_wdata = dm_wdata;
          if (if_req && (starve < 15)) starve++;
        end else begin
          arb_at = cyc + 1;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  bit found;

  task automatic reset_mid_txn();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #3;
      if (mem_req) found = 1'b1;
    end
    check("rst_wait_mem_req", found, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_async_mem_req", mem_req, 1'b0);
    check("rst_async_busy", busy, 1'b0);
    check("rst_async_dm_valid", dm_valid, 1'b0);
    check("rst_async_if_valid", if_valid, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_dm_valid", dm_valid, 1'b0);
    check("rst_if_rdata", if_rdata, '0);
    check("rst_dm_rdata", dm_rdata, '0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;

    if_pct = 40; dm_pct = 40; ready_pct = 60;
    repeat (400) @(posedge clk);

    // Continuous data traffic with fetch held: exercises starvation behaviour.
    if_pct = 100; dm_pct = 100; ready_pct = 100;
    repeat (80) @(posedge clk);

    if_pct = 30; dm_pct = 50; ready_pct = 20;
    repeat (300) @(posedge clk);

    ready_pct = 30;
    for (int r = 0; r < 3; r++) reset_mid_txn();

    if_pct = 50; dm_pct = 50; ready_pct = 70;
    repeat (300) @(posedge clk);

    if_pct = 0; dm_pct = 0; ready_pct = 100;
    repeat (60) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
